alt_vipvfr131_vfr_control_packet_decoder: RTL and testbench

//  Avalon-ST video sink stage directly downstream of the frame reader's stream output.

---
 rtl/alt_vipvfr131_vfr_control_packet_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_alt_vipvfr131_vfr_control_packet_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipvfr131_vfr_control_packet_decoder.sv
// Avalon-ST video sink stage: forwards every beat through one register slice,
// decodes control packets into width/height/interlaced and checks each video
// packet's pixel count against the decoded frame size.
module alt_vipvfr131_vfr_control_packet_decoder #(
  parameter int          BITS_PER_SYMBOL    = 8,
  parameter int          SYMBOLS_PER_BEAT   = 3,
  parameter logic [15:0] DEFAULT_WIDTH      = 16'd640,
  parameter logic [15:0] DEFAULT_HEIGHT     = 16'd480,
  parameter logic [3:0]  DEFAULT_INTERLACED = 4'd0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [15:0]                                 width,
  output logic [15:0]                                 height,
  output logic [3:0]                                  interlaced,
  output logic                                        ctrl_update,
  output logic                                        ctrl_error,
  output logic                                        frame_done,
  output logic                                        early_eop,
  output logic                                        late_eop
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CTRL  = 2'd1;
  localparam logic [1:0] ST_VIDEO = 2'd2;
  localparam logic [1:0] ST_USER  = 2'd3;

  // Output register slice
  logic          dout_valid_q;
  logic [DW-1:0] dout_data_q;
  logic          dout_sop_q, dout_eop_q;

  // Decoder state
  logic [1:0]  state_q, state_d;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic [3:0]  interlaced_q, interlaced_d;
  logic [4:0]  nib_cnt_q, nib_cnt_d;
  logic [35:0] nib_q, nib_d;          // nibble k lives in [4k+3:4k]
  logic [15:0] exp_w_q, exp_w_d, exp_lines_q, exp_lines_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        upd_q, upd_d, err_q, err_d, done_q, done_d, early_q, early_d, late_q, late_d;

  logic        accept;
  logic        ctrl_load;
  logic [31:0] nib_base;
  logic [31:0] nib_sum;
  logic [15:0] lines_now;
  logic [15:0] cmt_width, cmt_height;

  assign din_ready = dout_ready | ~dout_valid_q;
  assign accept    = din_valid & din_ready;
  assign ctrl_load = accept & ~din_sop & (state_q == ST_CTRL);
  assign nib_base  = {27'd0, nib_cnt_q};
  assign nib_sum   = nib_base + 32'(SYMBOLS_PER_BEAT);

  // Lines expected for the next video packet. (h+1)>>1 is written as
  // (h>>1)+h[0] so the 17-bit intermediate never needs to exist.
  always_comb begin
    lines_now = height_q;
    if (interlaced_q[3])
      lines_now = {1'b0, height_q[15:1]} + {15'd0, height_q[0] & ~interlaced_q[2]};
  end

  // Capture each payload nibble into its slot; slots past 8 are never written.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nib
      logic [3:0] slot_d;
      // Select the symbol that carries nibble gi in this beat, if any
      always_comb begin
        slot_d = nib_q[gi*4 +: 4];
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++)
          if (ctrl_load && (nib_base + 32'(s) == 32'(gi)))
            slot_d = din_data[s*BITS_PER_SYMBOL +: 4];
      end
      assign nib_d[gi*4 +: 4] = slot_d;
    end
  endgenerate

  // Nibble 0 is the most significant nibble of width, nibble 4 of height.
  assign cmt_width  = {nib_d[3:0],   nib_d[7:4],   nib_d[11:8],  nib_d[15:12]};
  assign cmt_height = {nib_d[19:16], nib_d[23:20], nib_d[27:24], nib_d[31:28]};

  // Packet decoder: header dispatch, control nibble gathering, pixel counting
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    interlaced_d = interlaced_q;
    nib_cnt_d    = nib_cnt_q;
    exp_w_d      = exp_w_q;
    exp_lines_d  = exp_lines_q;
    x_d          = x_q;
    y_d          = y_q;
    ovf_d        = ovf_q;
    upd_d        = 1'b0;
    err_d        = 1'b0;
    done_d       = 1'b0;
    early_d      = 1'b0;
    late_d       = 1'b0;

    if (accept) begin
      if (din_sop) begin
        // A new header always aborts whatever packet was in flight
        if (state_q == ST_VIDEO) early_d = 1'b1;
        if (state_q == ST_CTRL)  err_d   = 1'b1;
        nib_cnt_d = 5'd0;
        x_d       = 16'd0;
        y_d       = 16'd0;
        ovf_d     = 1'b0;
        case (din_data[3:0])
          4'hF: begin
            if (din_eop) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_CTRL;
            end
          end
          4'h0: begin
            exp_w_d     = width_q;
            exp_lines_d = lines_now;
            if (din_eop) begin
              if (width_q == 16'd0 || lines_now == 16'd0) done_d  = 1'b1;
              else                                         early_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_VIDEO;
            end
          end
          default: state_d = din_eop ? ST_IDLE : ST_USER;
        endcase
      end else begin
        case (state_q)
          ST_CTRL: begin
            nib_cnt_d = (nib_sum >= 32'd9) ? 5'd9 : nib_sum[4:0];
            if (din_eop) begin
              if (nib_sum >= 32'd9 && cmt_width != 16'd0 && cmt_height != 16'd0) begin
                width_d      = cmt_width;
                height_d     = cmt_height;
                interlaced_d = nib_d[35:32];
                upd_d        = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = ST_IDLE;
            end
          end
          ST_VIDEO: begin
            if (ovf_q || exp_w_q == 16'd0 || y_q >= exp_lines_q) begin
              ovf_d = 1'b1;
            end else if (x_q == exp_w_q - 16'd1) begin
              x_d = 16'd0;
              y_d = y_q + 16'd1;
            end else begin
              x_d = x_q + 16'd1;
            end
            if (din_eop) begin
              if (ovf_d)                                        late_d  = 1'b1;
              else if (exp_w_q == 16'd0 || y_d >= exp_lines_q) done_d  = 1'b1;
              else                                              early_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_USER: if (din_eop) state_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Register slice: load on accept, drop valid once the sink takes the beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
    end else if (accept) begin
      dout_valid_q <= 1'b1;
      dout_data_q  <= din_data;
      dout_sop_q   <= din_sop;
      dout_eop_q   <= din_eop;
    end else if (dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  // Decoder state and the status pulses that line up with the forwarded beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      width_q      <= DEFAULT_WIDTH;
      height_q     <= DEFAULT_HEIGHT;
      interlaced_q <= DEFAULT_INTERLACED;
      nib_cnt_q    <= 5'd0;
      nib_q        <= '0;
      exp_w_q      <= 16'd0;
      exp_lines_q  <= 16'd0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      ovf_q        <= 1'b0;
      upd_q        <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      early_q      <= 1'b0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      interlaced_q <= interlaced_d;
      nib_cnt_q    <= nib_cnt_d;
      nib_q        <= nib_d;
      exp_w_q      <= exp_w_d;
      exp_lines_q  <= exp_lines_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      upd_q        <= upd_d;
      err_q        <= err_d;
      done_q       <= done_d;
      early_q      <= early_d;
      late_q       <= late_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout_data   = dout_data_q;
  assign dout_sop    = dout_sop_q;
  assign dout_eop    = dout_eop_q;
  assign width       = width_q;
  assign height      = height_q;
  assign interlaced  = interlaced_q;
  assign ctrl_update = upd_q;
  assign ctrl_error  = err_q;
  assign frame_done  = done_q;
  assign early_eop   = early_q;
  assign late_eop    = late_q;

endmodule

// File: tb/tb_alt_vipvfr131_vfr_control_packet_decoder.sv
// Scoreboard bench: the driver pushes each accepted beat with the status
// pulses it should carry; a monitor pops and compares as beats leave dout.
module tb_alt_vipvfr131_vfr_control_packet_decoder;

  localparam logic [4:0] P_UPD   = 5'b10000;
  localparam logic [4:0] P_ERR   = 5'b01000;
  localparam logic [4:0] P_DONE  = 5'b00100;
  localparam logic [4:0] P_EARLY = 5'b00010;
  localparam logic [4:0] P_LATE  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_ready;
  logic        din_valid = 1'b0;
  logic [23:0] din_data = '0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic        dout_ready = 1'b1;
  logic        dout_valid;
  logic [23:0] dout_data;
  logic        dout_sop, dout_eop;
  logic [15:0] width, height;
  logic [3:0]  interlaced;
  logic        ctrl_update, ctrl_error, frame_done, early_eop, late_eop;

  alt_vipvfr131_vfr_control_packet_decoder dut (
    .clk(clk), .rst(rst),
    .din_ready(din_ready), .din_valid(din_valid), .din_data(din_data),
    .din_sop(din_sop), .din_eop(din_eop),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .width(width), .height(height), .interlaced(interlaced),
    .ctrl_update(ctrl_update), .ctrl_error(ctrl_error), .frame_done(frame_done),
    .early_eop(early_eop), .late_eop(late_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic        e;
    logic [4:0]  p;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rand_mode = 1'b0;
  bit   prev_valid = 1'b0;
  bit   prev_fire = 1'b0;
  logic [4:0] pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Sink backpressure: always ready unless random mode is on
  always @(posedge clk) begin
    #1;
    dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pulses checked when a beat first appears, data when it is taken
  always @(negedge clk) begin
    pulses = {ctrl_update, ctrl_error, frame_done, early_eop, late_eop};
    if (!rst) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      if (dout_valid && (!prev_valid || prev_fire)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", dout_data);
        end else begin
          chk("pulses", 32'(pulses), 32'(sb[0].p));
        end
      end else begin
        chk("idle_pulses", 32'(pulses), 32'd0);
      end
      if (dout_valid && dout_ready && sb.size() > 0) begin
        popped = sb.pop_front();
        chk("data", 32'(dout_data), 32'(popped.d));
        chk("sop", 32'(dout_sop), 32'(popped.s));
        chk("eop", 32'(dout_eop), 32'(popped.e));
        $display("beat data=%h sop=%0b eop=%0b pulses=%b", dout_data, dout_sop, dout_eop, popped.p);
      end
      prev_valid = dout_valid;
      prev_fire  = dout_valid && dout_ready;
    end
  end

  // Present one beat until accepted, then record its expected response
  task automatic send_beat(input logic [23:0] d, input logic s, input logic e, input logic [4:0] p);
    exp_t x;
    int t;
    if (rand_mode) begin
      repeat ($urandom_range(0, 2)) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    din_valid = 1'b1;
    din_data  = d;
    din_sop   = s;
    din_eop   = e;
    t = 0;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      t++;
      if (t > 1000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got din_ready=0, expected 1");
        break;
      end
    end
    x.d = d; x.s = s; x.e = e; x.p = p;
    sb.push_back(x);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                           input int nbeats, input logic [4:0] p, input logic [4:0] sop_p);
    logic [3:0]  nib [12];
    logic [23:0] d;
    for (int k = 0; k < 12; k++) nib[k] = 4'h7;
    nib[0] = w[15:12]; nib[1] = w[11:8]; nib[2] = w[7:4]; nib[3] = w[3:0];
    nib[4] = h[15:12]; nib[5] = h[11:8]; nib[6] = h[7:4]; nib[7] = h[3:0];
    nib[8] = il;
    send_beat(24'hABC12F, 1'b1, nbeats == 0, (nbeats == 0) ? (p | sop_p) : sop_p);
    for (int b = 0; b < nbeats; b++) begin
      d = {4'hA, nib[3*b+2], 4'h5, nib[3*b+1], 4'h3, nib[3*b]};
      send_beat(d, 1'b0, b == nbeats - 1, (b == nbeats - 1) ? p : 5'd0);
    end
  endtask

  task automatic send_video(input int n, input logic [4:0] p, input logic [4:0] sop_p);
    send_beat(24'h7A5C30, 1'b1, n == 0, (n == 0) ? (p | sop_p) : sop_p);
    for (int b = 0; b < n; b++)
      send_beat(24'($urandom()), 1'b0, b == n - 1, (b == n - 1) ? p : 5'd0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_regs(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    chk("width", 32'(width), 32'(w));
    chk("height", 32'(height), 32'(h));
    chk("interlaced", 32'(interlaced), 32'(il));
  endtask

  task automatic check_reset_outputs();
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_data", 32'(dout_data), 32'd0);
    chk("rst_dout_sop_eop", 32'({dout_sop, dout_eop}), 32'd0);
    chk("rst_pulses", 32'({ctrl_update, ctrl_error, frame_done, early_eop, late_eop}), 32'd0);
    check_regs(16'd640, 16'd480, 4'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Control packet decode 640x480, interlaced nibble 3
    send_ctrl(16'd640, 16'd480, 4'h3, 3, P_UPD, 5'd0);
    wait_drain();
    check_regs(16'd640, 16'd480, 4'h3);

    // 4x2 frame: exact, short, long
    send_ctrl(16'd4, 16'd2, 4'h0, 3, P_UPD, 5'd0);
    send_video(8, P_DONE, 5'd0);
    send_video(6, P_EARLY, 5'd0);
    send_video(10, P_LATE, 5'd0);
    wait_drain();
    check_regs(16'd4, 16'd2, 4'h0);

    // Rejected control packets keep the old size; extra nibbles are ignored
    send_ctrl(16'd0, 16'd7, 4'h0, 3, P_ERR, 5'd0);
    send_ctrl(16'd5, 16'd5, 4'h0, 2, P_ERR, 5'd0);
    send_ctrl(16'd9, 16'd9, 4'h0, 0, P_ERR, 5'd0);
    wait_drain();
    check_regs(16'd4, 16'd2, 4'h0);
    send_ctrl(16'd4, 16'd2, 4'h0, 4, P_UPD, 5'd0);

    // Single-beat video, user packet, and aborts by a new sop
    send_video(0, P_EARLY, 5'd0);
    send_beat(24'h00AB05, 1'b1, 1'b0, 5'd0);
    send_beat(24'h123456, 1'b0, 1'b0, 5'd0);
    send_beat(24'h654321, 1'b0, 1'b1, 5'd0);
    send_beat(24'h7A5C30, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) send_beat(24'($urandom()), 1'b0, 1'b0, 5'd0);
    send_ctrl(16'd4, 16'd2, 4'h0, 3, P_UPD, P_EARLY);
    send_beat(24'hABC12F, 1'b1, 1'b0, 5'd0);
    send_beat(24'hA35030, 1'b0, 1'b0, 5'd0);
    send_video(8, P_DONE, P_ERR);
    wait_drain();
    check_regs(16'd4, 16'd2, 4'h0);

    // Interlaced fields: 4x5 F0 -> 3 lines, F1 -> 2 lines (back-to-back after commit)
    send_ctrl(16'd4, 16'd5, 4'h8, 3, P_UPD, 5'd0);
    send_video(12, P_DONE, 5'd0);
    send_ctrl(16'd4, 16'd5, 4'hC, 3, P_UPD, 5'd0);
    send_video(8, P_DONE, 5'd0);
    wait_drain();
    check_regs(16'd4, 16'd5, 4'hC);

    // Random gaps and backpressure
    rand_mode = 1'b1;
    send_ctrl(16'd4, 16'd2, 4'h0, 3, P_UPD, 5'd0);
    send_video(8, P_DONE, 5'd0);
    send_video(6, P_EARLY, 5'd0);
    send_video(10, P_LATE, 5'd0);
    wait_drain();
    check_regs(16'd4, 16'd2, 4'h0);

    // Reset in the middle of a video packet drops in-flight data
    send_beat(24'h7A5C30, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) send_beat(24'($urandom()), 1'b0, 1'b0, 5'd0);
    rand_mode = 1'b0;
    din_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_ctrl(16'd4, 16'd2, 4'h0, 3, P_UPD, 5'd0);
    send_video(8, P_DONE, 5'd0);
    wait_drain();
    check_regs(16'd4, 16'd2, 4'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
